countdown_timer_ctrl: RTL

//  Parametrised mm:ss countdown timer controller; successor to the fixed 2-digit egg timer.

---
 rtl/countdown_timer_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
// mm:ss BCD countdown timer controller: switch capture with BCD clamping, one-second tick
// divider, borrow-chained decrement and alarm LED flashing. Optional macro: AUTO_RELOAD_EN.
module countdown_timer_ctrl #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 50000000,
  parameter int FLASH_DIV  = 12500000,
  parameter int NUM_LEDS   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_p,
  input  logic                    start_p,
  input  logic [4*MIN_DIGITS-1:0] sw_val,
  output logic [4*MIN_DIGITS-1:0] disp_min,
  output logic [7:0]              disp_sec,
  output logic [NUM_LEDS-1:0]     led,
  output logic [2:0]              state,
  output logic                    done
);

  // state   | meaning
  // SET_SEC | switches show and set seconds
  // SET_MIN | switches show and set minutes
  // PAUSED  | time held, waiting for start
  // RUN     | counting down once per tick
  // ALARM   | reached 00:00, LEDs flashing

  localparam int MW = 4 * MIN_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    SET_SEC = 3'd0,
    SET_MIN = 3'd1,
    PAUSED  = 3'd2,
    RUN     = 3'd3,
    ALARM   = 3'd4
  } state_t;

  state_t        cur_state;
  logic [MW-1:0] min_reg;
  logic [7:0]    sec_reg;
  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] flash_cnt;
`ifdef AUTO_RELOAD_EN
  logic [MW-1:0] min_saved;
  logic [7:0]    sec_saved;
`endif

  logic [7:0]    sec_sw;
  logic [MW-1:0] min_sw;
  logic [7:0]    sec_dec;
  logic [MW-1:0] min_dec;
  logic          min_borrow;
  logic          chain;
  logic          time_zero;
  logic          dec_zero;

  always_comb begin
    sec_sw[7:4] = (sw_val[7:4] > 4'd5) ? 4'd5 : sw_val[7:4];
    sec_sw[3:0] = (sw_val[3:0] > 4'd9) ? 4'd9 : sw_val[3:0];
    min_sw = sw_val;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (sw_val[4*i +: 4] > 4'd9) min_sw[4*i +: 4] = 4'd9;
    end
  end

  // seconds borrow out of 00 wraps to 59 and feeds the minute chain
  always_comb begin
    sec_dec    = sec_reg;
    min_borrow = 1'b0;
    if (sec_reg[3:0] != 4'd0) begin
      sec_dec[3:0] = sec_reg[3:0] - 4'd1;
    end else if (sec_reg[7:4] != 4'd0) begin
      sec_dec[3:0] = 4'd9;
      sec_dec[7:4] = sec_reg[7:4] - 4'd1;
    end else begin
      sec_dec    = 8'h59;
      min_borrow = 1'b1;
    end
  end

  always_comb begin
    min_dec = min_reg;
    chain   = min_borrow;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (chain) begin
        if (min_reg[4*i +: 4] == 4'd0) begin
          min_dec[4*i +: 4] = 4'd9;
        end else begin
          min_dec[4*i +: 4] = min_reg[4*i +: 4] - 4'd1;
          chain = 1'b0;
        end
      end
    end
  end

  assign time_zero = (sec_reg == 8'd0) && (min_reg == '0);
  assign dec_zero  = (sec_dec == 8'd0) && (min_dec == '0);

  always_comb begin
    disp_sec = sec_reg;
    disp_min = min_reg;
    case (cur_state)
      SET_SEC: disp_sec = sec_sw;
      SET_MIN: disp_min = min_sw;
      default: ;
    endcase
  end

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= SET_SEC;
      min_reg   <= '0;
      sec_reg   <= '0;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      led       <= '0;
      done      <= 1'b0;
`ifdef AUTO_RELOAD_EN
      min_saved <= '0;
      sec_saved <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (cur_state)
        SET_SEC: begin
          if (set_p) begin
            sec_reg   <= sec_sw;
`ifdef AUTO_RELOAD_EN
            sec_saved <= sec_sw;
`endif
            cur_state <= SET_MIN;
          end
        end
        SET_MIN: begin
          if (set_p) begin
            min_reg   <= min_sw;
`ifdef AUTO_RELOAD_EN
            min_saved <= min_sw;
`endif
            cur_state <= PAUSED;
          end
        end
        PAUSED: begin
          if (set_p) begin
            cur_state <= SET_SEC;
          end else if (start_p && !time_zero) begin
            cur_state <= RUN;
            tick_cnt  <= '0;
          end
        end
        RUN: begin
          if (set_p) begin
            cur_state <= SET_SEC;
            tick_cnt  <= '0;
          end else if (start_p) begin
            cur_state <= PAUSED;
            tick_cnt  <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (dec_zero) begin
              done <= 1'b1;
`ifdef AUTO_RELOAD_EN
              sec_reg <= sec_saved;
              min_reg <= min_saved;
`else
              sec_reg   <= sec_dec;
              min_reg   <= min_dec;
              cur_state <= ALARM;
              flash_cnt <= '0;
              led       <= '0;
`endif
            end else begin
              sec_reg <= sec_dec;
              min_reg <= min_dec;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ALARM: begin
          if (set_p || start_p) begin
            cur_state <= SET_SEC;
            led       <= '0;
            flash_cnt <= '0;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            led       <= ~led;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
        default: cur_state <= SET_SEC;
      endcase
    end
  end

endmodule
